// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the load lane-select/extend helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StWrite,
        StResp
    } lsu_state_e;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Byte offset 0 is the most significant lane.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'd0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    assign load_data_o = lane_extract(rdata_i, funct3_i, offset_i);

    always_comb begin
        merge_data_o = rdata_i;
        if (funct3_i[1:0] == 2'b00) begin
            case (offset_i)
                2'd0:    merge_data_o[31:24] = wdata_i[7:0];
                2'd1:    merge_data_o[23:16] = wdata_i[7:0];
                2'd2:    merge_data_o[15:8]  = wdata_i[7:0];
                default: merge_data_o[7:0]   = wdata_i[7:0];
            endcase
        end else if (funct3_i[1:0] == 2'b01) begin
            if (offset_i[1]) begin
                merge_data_o[15:0] = wdata_i[15:0];
            end else begin
                merge_data_o[31:16] = wdata_i[15:0];
            end
        end else begin
            merge_data_o = wdata_i;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-addressed data memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to report misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_err
);

    lsu_state_e    state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;

    logic          req_err;
    logic [AW+1:0] addr_lo;
    logic [31:0]   load_data;
    logic [31:0]   merge_data;

    always_comb begin
        req_err = !f3_legal(req_store, req_funct3) || (req_addr >= DEPTH * 4);
        addr_lo = req_addr[AW+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`else
        // Misaligned accesses are silently aligned down to the access size.
        if (req_funct3[1:0] == 2'b01) begin
            addr_lo[0] = 1'b0;
        end else if (req_funct3[1:0] == 2'b10) begin
            addr_lo[1:0] = 2'b00;
        end
`endif
    end

    lsu_lane_align u_lane_align (
        .offset_i     (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .rdata_i      (mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        req_ready   = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        resp_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d      = addr_lo;
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata;
                    resp_data_d = '0;
                    resp_err_d  = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_store) begin
                        state_d = StLoad;
                    end else if (req_funct3 == F3_W) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                mem_re      = 1'b1;
                mem_addr    = addr_q[AW+1:2];
                resp_data_d = load_data;
                state_d     = StResp;
            end
            StRmwRd: begin
                mem_re   = 1'b1;
                mem_addr = addr_q[AW+1:2];
                merge_d  = merge_data;
                state_d  = StWrite;
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q[AW+1:2];
                mem_wdata = (funct3_q == F3_W) ? wdata_q : merge_q;
                state_d   = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_re, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(32), .AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEAD_BEEF;
        if (i == 10) return 32'h0;
        return 32'h1357_9BDF ^ (i * 32'h0101_0101);
    endfunction

    logic [31:0] tb_mem [32];
    logic [31:0] ref_mem [32];
    logic        mem_init = 1'b1;
    int          we_cnt = 0, re_cnt = 0, conflict_cnt = 0;
    logic [4:0]  last_we_addr = '0;
    logic [31:0] last_we_data = '0;

    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= init_word(i);
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
        if (mem_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_re && mem_we) conflict_cnt <= conflict_cnt + 1;
    end

    function automatic logic m_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad = bad || (a >= 32'd128);
`ifdef LSU_MISALIGN_TRAP_EN
        bad = bad || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`endif
        return bad;
    endfunction

    function automatic logic [1:0] m_off(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return a[1:0];
`else
        if (f3[1:0] == 2'b01) return {a[1], 1'b0};
        if (f3[1:0] == 2'b10) return 2'b00;
        return a[1:0];
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[31 - 8 * off -: 8];
        h = off[1] ? w[15:0] : w[31:16];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        if (f3 == 3'd0) r[31 - 8 * off -: 8] = wd[7:0];
        else if (f3 == 3'd1) r[31 - 16 * off[1] -: 16] = wd[15:0];
        else r = wd;
        return r;
    endfunction

    function automatic int m_lat(input logic st, input logic [2:0] f3, input logic err);
        if (err) return 1;
        if (!st || f3 == 3'd2) return 2;
        return 3;
    endfunction

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat, input int hold);
        exp_t e;
        int   lat;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb_q.pop_front();
        check_eq("latency", lat, e.lat);
        check_eq("resp_data", resp_data, e.data);
        check_eq("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid = 1'b1;
                req_store = 1'b0;
                req_funct3 = 3'd2;
                req_addr  = 32'd0;
                @(posedge clk);
                #1;
                check_eq("stall_valid", {31'd0, resp_valid}, 32'd1);
                check_eq("stall_data", resp_data, e.data);
                check_eq("stall_ready", {31'd0, req_ready}, 32'd0);
            end
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk);
            #1 check_eq("idle_after_release", {31'd0, req_ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        if (st && !exp_err) ref_mem[a[6:2]] = m_store(ref_mem[a[6:2]], f3, m_off(f3, a), wd);
    endtask

    task automatic issue_model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        logic        err;
        logic [31:0] d;
        err = m_err(st, f3, a);
        d = (st || err) ? 32'd0 : m_load(ref_mem[a[6:2]], f3, m_off(f3, a));
        issue(st, f3, a, wd, d, err, m_lat(st, f3, err), 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int we0, re0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        reset = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;

        issue(1'b0, 3'd0, 32'd20, 32'd0, 32'hFFFF_FFDE, 1'b0, 2, 0);
        issue(1'b0, 3'd4, 32'd20, 32'd0, 32'h0000_00DE, 1'b0, 2, 0);
        issue(1'b0, 3'd1, 32'd22, 32'd0, 32'hFFFF_BEEF, 1'b0, 2, 0);
        issue(1'b0, 3'd5, 32'd22, 32'd0, 32'h0000_BEEF, 1'b0, 2, 0);
        issue(1'b0, 3'd2, 32'd20, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 4);

        we0 = we_cnt;
        issue(1'b1, 3'd0, 32'd41, 32'h0004_567F, 32'd0, 1'b0, 3, 0);
        check_eq("sb_we_pulses", we_cnt - we0, 32'd1);
        check_eq("sb_we_addr", {27'd0, last_we_addr}, 32'd10);
        check_eq("sb_we_data", last_we_data, 32'h007F_0000);
        issue(1'b0, 3'd2, 32'd40, 32'd0, 32'h007F_0000, 1'b0, 2, 0);

        we0 = we_cnt;
        re0 = re_cnt;
        issue(1'b0, 3'd2, 32'd128, 32'd0, 32'd0, 1'b1, 1, 0);
        issue(1'b0, 3'd3, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0);
        issue(1'b1, 3'd4, 32'd4, 32'd0, 32'd0, 1'b1, 1, 0);
        check_eq("err_no_we", we_cnt - we0, 32'd0);
        check_eq("err_no_re", re_cnt - re0, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        we0 = we_cnt;
        re0 = re_cnt;
        issue(1'b1, 3'd1, 32'd21, 32'h0000_1234, 32'd0, 1'b1, 1, 0);
        check_eq("mis_no_we", we_cnt - we0, 32'd0);
        check_eq("mis_no_re", re_cnt - re0, 32'd0);
        issue(1'b0, 3'd2, 32'd20, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0);
`else
        issue(1'b1, 3'd1, 32'd21, 32'h0000_1234, 32'd0, 1'b0, 3, 0);
        issue(1'b0, 3'd2, 32'd23, 32'd0, 32'h1234_BEEF, 1'b0, 2, 0);
`endif

        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_funct3 = 3'd1;
        req_addr = 32'd40;
        req_wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq("rmw_rd_re", {31'd0, mem_re}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        check_eq("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rstmid_no_we", we_cnt - we0, 32'd0);
        check_eq("rstmid_word10", tb_mem[10], ref_mem[10]);

        for (int n = 0; n < 40; n++) begin
            issue_model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        32'($urandom_range(0, 135)), $urandom);
        end

        for (int i = 0; i < 32; i++) check_eq($sformatf("mem_word_%0d", i), tb_mem[i], ref_mem[i]);
        check_eq("re_we_overlap", conflict_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly upstream of the data memory. Accepts one load/store request at a time from the execute stage, validates alignment and range, and drives the word-addressed data memory. It returns sign- or zero-extended load data, or store completion, to writeback over a valid/ready handshake. All sub-word stores are done as read-modify-write of whole words, so the memory only ever sees full-word writes.

Parameters:
DEPTH, 32, number of 32-bit words in data memory
AW, 5, word-index width (clog2(DEPTH))

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (size/sign)
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for SB/SH)
mem_re  out  1  memory read enable (combinational read, same cycle)
mem_we  out  1  memory write enable (written on clk edge)
mem_addr  out  AW  word index = byte address[AW+1:2]
mem_wdata  out  32  full word to write
mem_rdata  in  32  word read from memory
resp_valid  out  1  response present
resp_ready  in  1  writeback accepts response
resp_data  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; req_ready=1; mem_re=0, mem_we=0, resp_valid=0, resp_err=0, resp_data=0, mem_addr=0, mem_wdata=0. Any in-flight request is dropped and no write is issued.
- Byte lanes: offset 0 is bits [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0]. Halfword offset 0 is [31:16], offset 2 is [15:0].
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets err.
- Range check: req_addr >= DEPTH*4 sets err.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. Handshake is req_valid&req_ready; on it, latch addr, funct3, store flag and wdata. Next state:
  - err → RESP with resp_err=1, no memory access.
  - load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
- LOAD: mem_re=1. Capture mem_rdata. Extract the lane and sign- or zero-extend it into resp_data. Next state RESP.
- RMW_RD: mem_re=1. Merge the low byte/half of wdata into the addressed lane of mem_rdata and store the result in a merge register. Next state WRITE.
- WRITE: mem_we=1. mem_wdata = merge register (SB/SH) or latched wdata (SW). Next state RESP.
- RESP: resp_valid=1. resp_data/resp_err stay stable until resp_ready. On resp_ready go to IDLE; req_ready is 1 on the following cycle, so there is no back-to-back acceptance.
- Latency from accept edge to resp_valid high:
  - Error requests: 1 cycle.
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Requests presented outside IDLE are ignored (req_ready=0).
- mem_re and mem_we are never high in the same cycle. mem_we is high for exactly one cycle per successful store.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]≠0) set resp_err=1 with no memory access.
- Undefined: the low address bits below the access size are cleared (access aligned down), the access is performed, and misalignment never sets resp_err.
- Range and funct3 errors are reported in both builds.

Decomposition:
Package lsu_pkg holds:
- funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
- state enumeration;
- lane-select/extend function.

One natural combinational sub-module, lsu_lane_align, handles load extraction/extension and store merge given offset and size.

Test Plan:
- Memory word 5 = 0xDEADBEEF. LB addr 20 → resp_data 0xFFFFFFDE, resp_valid 2 cycles after accept; LBU addr 20 → 0x000000DE.
- LH addr 22 on word 5 → 0xFFFFBEEF; LHU addr 22 → 0x0000BEEF; LW addr 20 → 0xDEADBEEF.
- Word 10 = 0. SB addr 41, wdata 0x0004567F → one mem_we pulse with mem_addr=10, mem_wdata=0x007F0000; resp_valid 3 cycles after accept, resp_data 0.
- With LSU_MISALIGN_TRAP_EN: SH addr 21 → resp_err=1 after 1 cycle, mem_re and mem_we never asserted. LW addr 128 (DEPTH=32) → resp_err=1 in both builds.
- Reset driven low during RMW_RD of SH addr 40 → next edge IDLE, mem_we never asserted, word 10 unchanged, req_ready=1.
- resp_ready held low 4 cycles in RESP → resp_valid/resp_data stable, req_valid ignored. Release → IDLE, next request accepted one cycle later.
